// File: rtl/conf_int_add_sel_ctrl.sv
// Selects accurate vs approximate adder from windowed |acc - apx| error sums.
// Ports: clk, rst (async active-low), in_valid, d__acc, d__apx, clr,
//   acc__sel, win_done, err_sum; with CONF_ADD_SEL_CTRL_STATS_EN also
//   err_max and breach_cnt.
module conf_int_add_sel_ctrl #(
  parameter int DATA_PATH_BITWIDTH = 32,
  parameter int WIN_LOG2           = 4,
  parameter int ERR_THRESH         = 4096,
  parameter int HOLD_WINDOWS       = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  input  logic [DATA_PATH_BITWIDTH:0]      d__acc,
  input  logic [DATA_PATH_BITWIDTH:0]      d__apx,
  input  logic                             clr,
  output logic                             acc__sel,
  output logic                             win_done,
  output logic [DATA_PATH_BITWIDTH+WIN_LOG2:0] err_sum
`ifdef CONF_ADD_SEL_CTRL_STATS_EN
  ,
  output logic [DATA_PATH_BITWIDTH:0]      err_max,
  output logic [15:0]                      breach_cnt
`endif
);

  localparam int DW = DATA_PATH_BITWIDTH + 1;
  localparam int SW = DW + WIN_LOG2;

  localparam logic [SW-1:0] THRESH    = SW'(ERR_THRESH);
  localparam logic [7:0]    HOLD_INIT = 8'(HOLD_WINDOWS);

  typedef enum logic {
    APX = 1'b0,
    ACC = 1'b1
  } state_t;

  logic [DW-1:0]       err;
  logic [SW-1:0]       acc_q;
  logic [SW-1:0]       sum_nxt;
  logic [WIN_LOG2-1:0] cnt_q;
  logic                take;
  logic                last;
  logic                breach;

  state_t              state_q;
  state_t              state_d;
  logic [7:0]          hold_q;
  logic [7:0]          hold_d;

  // Sample error and window arithmetic
  always_comb begin
    if (d__acc >= d__apx) begin
      err = d__acc - d__apx;
    end else begin
      err = d__apx - d__acc;
    end
  end

  // clr wins over a coincident sample
  assign take    = in_valid & ~clr;
  assign last    = take & (cnt_q == '1);
  assign sum_nxt = acc_q + SW'(err);
  assign breach  = sum_nxt > THRESH;

  // Accumulator, sample counter and window result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      win_done <= 1'b0;
      err_sum  <= '0;
    end else begin
      win_done <= last;
      if (clr) begin
        acc_q <= '0;
        cnt_q <= '0;
      end else if (take) begin
        if (last) begin
          // window closes: publish the sum including this sample
          acc_q   <= '0;
          cnt_q   <= '0;
          err_sum <= sum_nxt;
        end else begin
          acc_q <= sum_nxt;
          cnt_q <= cnt_q + WIN_LOG2'(1);
        end
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ACC;
      hold_q  <= HOLD_INIT;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // FSM: next state, evaluated only at window closure
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (last) begin
      unique case (state_q)
        APX: begin
          if (breach) begin
            state_d = ACC;
            hold_d  = HOLD_INIT;
          end
        end
        ACC: begin
          if (breach) begin
            hold_d = HOLD_INIT;
          end else if (hold_q <= 8'd1) begin
            state_d = APX;
            hold_d  = 8'd0;
          end else begin
            hold_d = hold_q - 8'd1;
          end
        end
        default: begin
          state_d = ACC;
          hold_d  = HOLD_INIT;
        end
      endcase
    end
  end

  // FSM: output decode straight from the state flop
  always_comb begin
    acc__sel = 1'b0;
    unique case (state_q)
      ACC:     acc__sel = 1'b1;
      default: acc__sel = 1'b0;
    endcase
  end

`ifdef CONF_ADD_SEL_CTRL_STATS_EN
  // Optional statistics
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_max    <= '0;
      breach_cnt <= '0;
    end else if (clr) begin
      err_max    <= '0;
      breach_cnt <= '0;
    end else begin
      if (take && (err > err_max)) begin
        err_max <= err;
      end
      if (last && breach && (breach_cnt != 16'hFFFF)) begin
        breach_cnt <= breach_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_conf_int_add_sel_ctrl.sv
// Bench for conf_int_add_sel_ctrl: vector table of whole windows plus
// hand sequences; window results are checked through a scoreboard queue.
module tb_conf_int_add_sel_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        clr = 1'b0;
  logic [32:0] d__acc = '0;
  logic [32:0] d__apx = '0;
  logic        acc__sel;
  logic        win_done;
  logic [36:0] err_sum;
`ifdef CONF_ADD_SEL_CTRL_STATS_EN
  logic [32:0] err_max;
  logic [15:0] breach_cnt;
`endif

  always #5 clk = ~clk;

  conf_int_add_sel_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .d__acc   (d__acc),
    .d__apx   (d__apx),
    .clr      (clr),
    .acc__sel (acc__sel),
    .win_done (win_done),
    .err_sum  (err_sum)
`ifdef CONF_ADD_SEL_CTRL_STATS_EN
    ,
    .err_max    (err_max),
    .breach_cnt (breach_cnt)
`endif
  );

  typedef struct {
    logic [36:0] sum;
    logic        sel;
  } exp_t;

  typedef struct {
    logic [32:0] a;
    logic [32:0] b;
    logic        gap;
    logic [36:0] sum;
    logic        sel;
  } vec_t;

  exp_t q[$];
  vec_t tbl[12];

  int checks = 0;
  int passes = 0;

  logic        prev_sel = 1'b1;
  logic [36:0] last_sum = '0;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got === want) begin
      passes++;
    end else begin
      $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
    end
  endtask

  task automatic put(input logic [32:0] a, input logic [32:0] b,
                     input logic v, input logic c);
    @(negedge clk);
    d__acc   = a;
    d__apx   = b;
    in_valid = v;
    clr      = c;
  endtask

  task automatic idle();
    put('0, '0, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [36:0] s, input logic sel);
    exp_t e;
    e.sum = s;
    e.sel = sel;
    q.push_back(e);
  endtask

  task automatic window(input logic [32:0] a, input logic [32:0] b,
                        input logic gap);
    for (int i = 0; i < 16; i++) begin
      put(a, b, 1'b1, 1'b0);
      if (gap && (i % 2 == 1)) idle();
    end
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      chk("drain_timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
  endtask

  // Output monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      prev_sel = 1'b1;
      last_sum = '0;
    end else if (win_done) begin
      if (q.size() == 0) begin
        chk("spurious_win_done", 64'(win_done), 64'd0);
      end else begin
        e = q.pop_front();
        chk("err_sum", 64'(err_sum), 64'(e.sum));
        chk("acc_sel", 64'(acc__sel), 64'(e.sel));
      end
      prev_sel = acc__sel;
      last_sum = err_sum;
    end else begin
      chk("sel_hold", 64'(acc__sel), 64'(prev_sel));
      chk("sum_hold", 64'(err_sum), 64'(last_sum));
    end
  end

  initial begin
    tbl[0]  = '{33'd100,  33'd100, 1'b0, 37'd0,    1'b1};
    tbl[1]  = '{33'd100,  33'd100, 1'b1, 37'd0,    1'b1};
    tbl[2]  = '{33'd100,  33'd100, 1'b0, 37'd0,    1'b1};
    tbl[3]  = '{33'd100,  33'd100, 1'b0, 37'd0,    1'b0};
    tbl[4]  = '{33'd256,  33'd0,   1'b1, 37'd4096, 1'b0};
    tbl[5]  = '{33'd1000, 33'd700, 1'b0, 37'd4800, 1'b1};
    tbl[6]  = '{33'd0,    33'd0,   1'b0, 37'd0,    1'b1};
    tbl[7]  = '{33'd0,    33'd0,   1'b0, 37'd0,    1'b1};
    tbl[8]  = '{33'd0,    33'd0,   1'b0, 37'd0,    1'b1};
    tbl[9]  = '{33'd0,    33'd0,   1'b0, 37'd0,    1'b0};
    tbl[10] = '{33'd5,    33'd10,  1'b1, 37'd80,   1'b0};
    tbl[11] = '{33'h1_FFFF_FFFF, 33'd0, 1'b0,
                37'h1F_FFFF_FFF0, 1'b1};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_acc_sel", 64'(acc__sel), 64'd1);
    chk("rst_win_done", 64'(win_done), 64'd0);
    chk("rst_err_sum", 64'(err_sum), 64'd0);
    rst = 1'b1;

    // Table of whole windows
    for (int i = 0; i < 12; i++) begin
      push(tbl[i].sum, tbl[i].sel);
      window(tbl[i].a, tbl[i].b, tbl[i].gap);
    end
    drain();
`ifdef CONF_ADD_SEL_CTRL_STATS_EN
    chk("stat_err_max", 64'(err_max), 64'h1_FFFF_FFFF);
    chk("stat_breach", 64'(breach_cnt), 64'd2);
`endif

    // Partial window, then clr with a discarded sample
    for (int i = 0; i < 8; i++) put(33'd10, 33'd5, 1'b1, 1'b0);
    put(33'd5000, 33'd0, 1'b1, 1'b1);
    push(37'd16, 1'b1);
    window(33'd1, 33'd0, 1'b0);

    // Back-to-back windows, no dropped sample
    push(37'd4080, 1'b1);
    push(37'd4080, 1'b1);
    for (int i = 0; i < 32; i++) begin
      put(33'h1_0000_00FF, 33'h1_0000_0000, 1'b1, 1'b0);
    end
    drain();
`ifdef CONF_ADD_SEL_CTRL_STATS_EN
    chk("clr_err_max", 64'(err_max), 64'd255);
    chk("clr_breach", 64'(breach_cnt), 64'd0);
`endif

    // Reset in the middle of a window
    for (int i = 0; i < 10; i++) put(33'd7, 33'd0, 1'b1, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_sel", 64'(acc__sel), 64'd1);
    chk("mid_rst_done", 64'(win_done), 64'd0);
    chk("mid_rst_sum", 64'(err_sum), 64'd0);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    push(37'd32, 1'b1);
    window(33'd2, 33'd0, 1'b0);
    drain();
`ifdef CONF_ADD_SEL_CTRL_STATS_EN
    chk("rst_err_max", 64'(err_max), 64'd2);
    chk("rst_breach", 64'(breach_cnt), 64'd0);
`endif

    // Hold must have been reloaded by reset
    push(37'd0, 1'b1);
    push(37'd0, 1'b1);
    push(37'd0, 1'b0);
    for (int i = 0; i < 3; i++) window(33'd9, 33'd9, 1'b0);
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
